// File: rtl/_reg_arbiter_pkg.sv
// _reg_arbiter_pkg: shared FSM state encoding and default sizes for the arbiter
//    state_t   : IDLE=00, WR0=01, WR1=10 (11 is illegal and falls back to IDLE)
//    WIDTH_DEF : default shared register width
//    CNT_W_DEF : default completed-write counter width
package _reg_arbiter_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, WR0 = 2'b01, WR1 = 2'b10} state_t;
   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/_dff_en.sv
// _dff_en: WIDTH-bit D register with load enable and asynchronous active-low clear
//    clk     : rising-edge clock
//    reset_n : asynchronous clear, active low
//    en      : load enable
//    d       : data in
//    q       : registered data out
module _dff_en #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (en) q <= d;
endmodule

// File: rtl/_reg_arbiter.sv
// _reg_arbiter: two-requester round-robin write arbiter for a shared register
//    clk, reset_n : rising-edge clock, asynchronous active-low reset
//    req0/d0      : requester 0 write request and data
//    req1/d1      : requester 1 write request and data
//    gnt0/gnt1    : one-cycle registered grants, never high together
//    q, valid     : shared register contents and written-since-reset flag
//    last         : index of the most recent writer (1 after reset so 0 wins first tie)
//    wcnt         : wrapping completed-write counter
module _reg_arbiter
   import _reg_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] d0,
   input  logic             req1,
   input  logic [WIDTH-1:0] d1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic             last,
   output logic [CNT_W-1:0] wcnt
);
   state_t state, next_state;
   logic   commit;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= next_state;

   // Every non-IDLE state (including the illegal code) returns to IDLE,
   // so a grant lasts exactly one cycle. On a tie, last=1 favours requester 0.
   always_comb begin
      next_state = IDLE;
      if (state == IDLE)
         next_state = (req0 && (!req1 || last)) ? WR0 : (req1 ? WR1 : IDLE);
   end

   always_comb begin
      gnt0   = state == WR0;
      gnt1   = state == WR1;
      commit = gnt0 || gnt1;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         valid <= 1'b0;
         last  <= 1'b1;
         wcnt  <= '0;
      end else if (commit) begin
         valid <= 1'b1;
         last  <= gnt1;
         wcnt  <= wcnt + CNT_W'(1);
      end

   _dff_en #(.WIDTH(WIDTH)) u_q (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (commit),
      .d       (gnt1 ? d1 : d0),
      .q       (q)
   );
endmodule

// File: tb/tb__reg_arbiter.sv
// tb__reg_arbiter: randomized self-checking bench for _reg_arbiter against a transaction-level model
module tb__reg_arbiter;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] d0 = '0, d1 = '0;
   logic       gnt0, gnt1, valid, last;
   logic [7:0] q;
   logic [3:0] wcnt;

   int total = 0;
   int bad = 0;

   // model: owner = requester currently holding the grant (-1 when none)
   int       m_owner;
   bit [7:0] m_q;
   bit       m_valid, m_last;
   int       m_wcnt;

   _reg_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .req0(req0), .d0(d0), .req1(req1), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .q(q), .valid(valid), .last(last), .wcnt(wcnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner = -1;
      m_q = '0;
      m_valid = 1'b0;
      m_last = 1'b1;
      m_wcnt = 0;
   endtask

   // one clock: model reacts to the inputs present at the rising edge, outputs sampled at the falling edge
   task automatic step();
      @(posedge clk);
      if (m_owner >= 0) begin
         m_q = (m_owner == 0) ? d0 : d1;
         m_valid = 1'b1;
         m_last = (m_owner == 1);
         m_wcnt = (m_wcnt + 1) % 16;
         m_owner = -1;
      end else if (req0 && req1) m_owner = m_last ? 0 : 1;
      else if (req0) m_owner = 0;
      else if (req1) m_owner = 1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      req0 = 1'b1; req1 = 1'b1; d0 = 8'h5A; d1 = 8'hC3;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({gnt0, gnt1, q, valid, last, wcnt} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0}) begin
         bad++;
         $display("FAIL reset: got g=%b%b q=%h v=%b l=%b w=%0d want g=00 q=00 v=0 l=1 w=0", gnt0, gnt1, q, valid, last, wcnt);
      end
      req0 = 1'b0; req1 = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_reset();
      req0 = 1'b1; d0 = 8'hA5;
      step();
      req0 = 1'b0;
      total++;
      if ({gnt0, gnt1, q, valid} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL single_grant: got g=%b%b q=%h v=%b want g=10 q=00 v=0", gnt0, gnt1, q, valid);
      end
      step();
      total++;
      if ({gnt0, gnt1, q, valid, last, wcnt} !== {1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 4'd1}) begin
         bad++;
         $display("FAIL single_commit: got g=%b%b q=%h v=%b l=%b w=%0d want g=00 q=a5 v=1 l=0 w=1", gnt0, gnt1, q, valid, last, wcnt);
      end
   endtask

   task automatic test_tie();
      bit [7:0] want [4] = '{8'h11, 8'h11, 8'h22, 8'h22};
      do_reset();
      req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
      for (int i = 0; i < 4; i++) begin
         step();
         step();
         total++;
         if (q !== want[i % 2 * 2] || wcnt !== 4'(i + 1)) begin
            bad++;
            $display("FAIL tie_write%0d: got q=%h w=%0d want q=%h w=%0d", i, q, wcnt, want[i % 2 * 2], i + 1);
         end
         total++;
         if (gnt0 && gnt1) begin
            bad++;
            $display("FAIL tie_exclusive%0d: got g=11 want at most one grant", i);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
   endtask

   task automatic test_drop();
      int w0;
      w0 = m_wcnt;
      req1 = 1'b1; d1 = 8'h3C;
      step();
      total++;
      if (gnt1 !== 1'b1) begin
         bad++;
         $display("FAIL drop_grant: got gnt1=%b want 1", gnt1);
      end
      req1 = 1'b0;
      step();
      total++;
      if (q !== 8'h3C || wcnt !== 4'((w0 + 1) % 16) || last !== 1'b1) begin
         bad++;
         $display("FAIL drop_commit: got q=%h w=%0d l=%b want q=3c w=%0d l=1", q, wcnt, last, (w0 + 1) % 16);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req0 = 1'b1; d0 = 8'hFF;
      step();
      req0 = 1'b0;
      total++;
      if (gnt0 !== 1'b1) begin
         bad++;
         $display("FAIL midreset_grant: got gnt0=%b want 1", gnt0);
      end
      reset_n = 1'b0;
      model_reset();
      #1;
      total++;
      if ({gnt0, gnt1, q, valid, last, wcnt} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0}) begin
         bad++;
         $display("FAIL midreset_async: got g=%b%b q=%h v=%b l=%b w=%0d want g=00 q=00 v=0 l=1 w=0", gnt0, gnt1, q, valid, last, wcnt);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) step();
      total++;
      if (q !== 8'h00 || valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_nowrite: got q=%h v=%b want q=00 v=0", q, valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      req0 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         d0 = 8'(i);
         step();
         step();
         if (i >= 15) begin
            total++;
            if (wcnt !== 4'(i % 16) || valid !== 1'b1 || q !== 8'(i)) begin
               bad++;
               $display("FAIL wrap%0d: got w=%0d v=%b q=%h want w=%0d v=1 q=%h", i, wcnt, valid, q, i % 16, 8'(i));
            end
         end
      end
      req0 = 1'b0;
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req0 = 1'($urandom_range(0, 1));
         req1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         step();
         total++;
         if ({gnt0, gnt1, q, valid, last, wcnt} !== {m_owner == 0, m_owner == 1, m_q, m_valid, m_last, 4'(m_wcnt)}) begin
            bad++;
            $display("FAIL random%0d: got g=%b%b q=%h v=%b l=%b w=%0d want g=%b%b q=%h v=%b l=%b w=%0d",
                     i, gnt0, gnt1, q, valid, last, wcnt, m_owner == 0, m_owner == 1, m_q, m_valid, m_last, m_wcnt);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_tie();
      test_drop();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
